player_collision_manager: RTL and testbench

PLAYER_COLLISION_MANAGER -- requirements
Module: player_collision_manager

---
 rtl/player_collision_manager.sv | 164 ++++++++++++++++
 tb/tb_player_collision_manager.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/player_collision_manager.sv
// Player collision manager: turns per-pixel hitbox/obstacle overlaps into
// at most one life loss per frame, then runs a blinking invincibility
// window measured in frames. Frames are delimited by the scan position
// arriving at the origin (0,0).
module player_collision_manager #(
    parameter int START_LIVES       = 3,
    parameter int INVINCIBLE_FRAMES = 120,
    parameter int BLINK_SHIFT       = 3
) (
    input  logic       clock_100mhz,
    input  logic       reset,
    input  logic       game_active,
    input  logic [6:0] pixel_x,
    input  logic [5:0] pixel_y,
    input  logic       is_player_hitbox,
    input  logic       is_obstacle,
    output logic       player_is_invincible,
    output logic       player_visible,
    output logic [1:0] lives,
    output logic       hit_pulse,
    output logic       game_over
);

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_PLAYING    = 2'd1;
    localparam logic [1:0] ST_INVINCIBLE = 2'd2;
    localparam logic [1:0] ST_GAME_OVER  = 2'd3;

    localparam logic [1:0] START_LIVES_L = 2'(START_LIVES);
    localparam logic [7:0] INV_FRAMES_L  = 8'(INVINCIBLE_FRAMES);

    logic [1:0] state_q,         state_d;
    logic [1:0] lives_q,         lives_d;
    logic [7:0] counter_q,       counter_d;
    logic       hit_pending_q,   hit_pending_d;
    logic [6:0] prev_x_q,        prev_x_d;
    logic [5:0] prev_y_q,        prev_y_d;
    logic       hit_pulse_q,     hit_pulse_d;
    logic       game_over_q,     game_over_d;
    logic       invincible_q,    invincible_d;
    logic       visible_q,       visible_d;

    logic frame_tick;
    logic overlap;
    logic hit_now;

    // Frame boundary detection and hit qualification for the ending frame.
    always_comb begin
        frame_tick = (pixel_x == 7'd0) && (pixel_y == 6'd0) &&
                     !((prev_x_q == 7'd0) && (prev_y_q == 6'd0));
        overlap    = is_player_hitbox && is_obstacle;
        // An overlap on the tick cycle itself still belongs to the ending frame.
        hit_now    = hit_pending_q || overlap;
    end

    // Next-state logic: game FSM, lives, invincibility counter and outputs.
    always_comb begin
        state_d       = state_q;
        lives_d       = lives_q;
        counter_d     = counter_q;
        hit_pending_d = hit_pending_q || overlap;
        prev_x_d      = pixel_x;
        prev_y_d      = pixel_y;
        hit_pulse_d   = 1'b0;

        if (!game_active) begin
            // Leaving the game keeps the lives display but drops everything else.
            state_d       = ST_IDLE;
            hit_pending_d = 1'b0;
            counter_d     = 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d       = ST_PLAYING;
                    lives_d       = START_LIVES_L;
                    hit_pending_d = 1'b0;
                    counter_d     = 8'd0;
                end
                ST_PLAYING: begin
                    if (frame_tick) begin
                        hit_pending_d = 1'b0;
                        if (hit_now) begin
                            // Only reachable with lives >= 1, so no underflow.
                            lives_d     = lives_q - 2'd1;
                            hit_pulse_d = 1'b1;
                            if (lives_q == 2'd1) begin
                                state_d = ST_GAME_OVER;
                            end else begin
                                state_d   = ST_INVINCIBLE;
                                counter_d = INV_FRAMES_L;
                            end
                        end
                    end
                end
                ST_INVINCIBLE: begin
                    if (frame_tick) begin
                        // Hits gathered while invincible are discarded every frame.
                        hit_pending_d = 1'b0;
                        if (counter_q <= 8'd1) begin
                            counter_d = 8'd0;
                            state_d   = ST_PLAYING;
                        end else begin
                            counter_d = counter_q - 8'd1;
                        end
                    end
                end
                ST_GAME_OVER: begin
                    lives_d       = 2'd0;
                    hit_pending_d = 1'b0;
                end
                default: begin
                    state_d       = ST_IDLE;
                    hit_pending_d = 1'b0;
                    counter_d     = 8'd0;
                end
            endcase
        end

        // Status outputs are registered alongside the state they describe.
        invincible_d = (state_d == ST_INVINCIBLE);
        game_over_d  = (state_d == ST_GAME_OVER);
        if (state_d == ST_PLAYING) begin
            visible_d = 1'b1;
        end else if (state_d == ST_INVINCIBLE) begin
            visible_d = !counter_d[BLINK_SHIFT];
        end else begin
            visible_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock_100mhz) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            lives_q       <= START_LIVES_L;
            counter_q     <= 8'd0;
            hit_pending_q <= 1'b0;
            prev_x_q      <= 7'd0;
            prev_y_q      <= 6'd0;
            hit_pulse_q   <= 1'b0;
            game_over_q   <= 1'b0;
            invincible_q  <= 1'b0;
            visible_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            lives_q       <= lives_d;
            counter_q     <= counter_d;
            hit_pending_q <= hit_pending_d;
            prev_x_q      <= prev_x_d;
            prev_y_q      <= prev_y_d;
            hit_pulse_q   <= hit_pulse_d;
            game_over_q   <= game_over_d;
            invincible_q  <= invincible_d;
            visible_q     <= visible_d;
        end
    end

    assign player_is_invincible = invincible_q;
    assign player_visible       = visible_q;
    assign lives                = lives_q;
    assign hit_pulse            = hit_pulse_q;
    assign game_over            = game_over_q;

endmodule

// File: tb/tb_player_collision_manager.sv
// Bench for player_collision_manager: compressed frames (a few random
// pixels, then the origin) with random overlaps, checked every cycle
// against a frame-level game model.
module tb_player_collision_manager;

    localparam int START_LIVES = 3;
    localparam int INV_FRAMES  = 4;
    localparam int BLINK_SHIFT = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       ga;
    logic [6:0] px;
    logic [5:0] py;
    logic       hb;
    logic       ob;
    logic       inv;
    logic       vis;
    logic [1:0] lives;
    logic       pulse;
    logic       gover;

    int total = 0;
    int bad   = 0;
    int pulses_seen = 0;

    // Reference model: game in progress, lives, frames of invincibility left.
    bit m_in_game;
    int m_lives;
    int m_left;
    bit m_over;
    bit m_pend;
    bit m_pulse;
    int m_px;
    int m_py;

    player_collision_manager #(
        .START_LIVES(START_LIVES),
        .INVINCIBLE_FRAMES(INV_FRAMES),
        .BLINK_SHIFT(BLINK_SHIFT)
    ) dut (
        .clock_100mhz(clk),
        .reset(rst),
        .game_active(ga),
        .pixel_x(px),
        .pixel_y(py),
        .is_player_hitbox(hb),
        .is_obstacle(ob),
        .player_is_invincible(inv),
        .player_visible(vis),
        .lives(lives),
        .hit_pulse(pulse),
        .game_over(gover)
    );

    always #5 clk = ~clk;

    task automatic model_update();
        bit tick;
        bit ov;
        bit hit;
        tick = (px == 0 && py == 0) && !(m_px == 0 && m_py == 0);
        ov = hb && ob;
        m_pulse = 0;
        if (rst) begin
            m_in_game = 0; m_lives = START_LIVES; m_left = 0;
            m_over = 0; m_pend = 0; m_px = 0; m_py = 0;
            return;
        end
        m_px = px;
        m_py = py;
        if (!ga) begin
            m_in_game = 0; m_pend = 0; m_left = 0; m_over = 0;
        end else if (!m_in_game) begin
            m_in_game = 1; m_lives = START_LIVES; m_pend = 0; m_left = 0; m_over = 0;
        end else if (m_over) begin
            m_pend = 0;
        end else if (tick) begin
            hit = m_pend || ov;
            m_pend = 0;
            if (m_left > 0) begin
                m_left = m_left - 1;
            end else if (hit) begin
                m_lives = m_lives - 1;
                m_pulse = 1;
                if (m_lives == 0) m_over = 1;
                else m_left = INV_FRAMES;
            end
        end else begin
            m_pend = m_pend || ov;
        end
    endtask

    task automatic check(input string tag);
        bit e_inv;
        bit e_vis;
        e_inv = m_in_game && !m_over && (m_left > 0);
        e_vis = m_in_game && !m_over && ((m_left == 0) || (((m_left >> BLINK_SHIFT) & 1) == 0));
        total++;
        assert (lives === 2'(m_lives)) else begin
            bad++; $error("FAIL %s lives got %0d expected %0d", tag, lives, m_lives);
        end
        total++;
        assert (pulse === m_pulse) else begin
            bad++; $error("FAIL %s hit_pulse got %0b expected %0b", tag, pulse, m_pulse);
        end
        total++;
        assert (inv === e_inv) else begin
            bad++; $error("FAIL %s invincible got %0b expected %0b", tag, inv, e_inv);
        end
        total++;
        assert (vis === e_vis) else begin
            bad++; $error("FAIL %s visible got %0b expected %0b", tag, vis, e_vis);
        end
        total++;
        assert (gover === m_over) else begin
            bad++; $error("FAIL %s game_over got %0b expected %0b", tag, gover, m_over);
        end
        if (pulse === 1'b1) pulses_seen++;
    endtask

    task automatic step(input bit r, input bit g, input int x, input int y,
                        input bit h, input bit o, input string tag);
        rst = r; ga = g; px = 7'(x); py = 6'(y); hb = h; ob = o;
        @(posedge clk);
        model_update();
        #1;
        check(tag);
    endtask

    // One compressed frame: len scan pixels (never the origin), nhit of them
    // overlapping, then the origin held for hold cycles.
    task automatic frame(input int len, input int nhit, input bit tick_hit,
                         input int hold, input string tag);
        int x;
        int y;
        bit h;
        bit o;
        for (int i = 0; i < len; i++) begin
            x = $urandom_range(1, 95);
            y = $urandom_range(0, 63);
            if (i < nhit) begin
                h = 1; o = 1;
                if (nhit == 1) begin x = 40; y = 20; end
            end else begin
                h = 1'($urandom_range(0, 1));
                o = h ? 1'b0 : 1'($urandom_range(0, 1));
            end
            step(0, 1, x, y, h, o, tag);
        end
        for (int j = 0; j < hold; j++)
            step(0, 1, 0, 0, (j == 0) ? tick_hit : 1'b0, (j == 0) ? tick_hit : 1'b0, tag);
    endtask

    task automatic expect_val(input string tag, input int got, input int exp);
        total++;
        assert (got == exp) else begin
            bad++; $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        int p0;
        m_in_game = 0; m_lives = START_LIVES; m_left = 0; m_over = 0;
        m_pend = 0; m_pulse = 0; m_px = 0; m_py = 0;
        rst = 1; ga = 0; px = 0; py = 0; hb = 0; ob = 0;

        // Reset state
        step(1, 0, 0, 0, 0, 0, "reset");
        step(1, 1, 33, 7, 1, 1, "reset_override");
        step(0, 0, 0, 0, 0, 0, "idle");

        // Start the game, one overlap at (40,20): 3 -> 2, invincible
        step(0, 1, 5, 5, 0, 0, "start");
        p0 = pulses_seen;
        frame(6, 1, 0, 1, "single_hit");
        step(0, 1, 9, 9, 0, 0, "after_hit");
        expect_val("single_hit_lives", lives, 2);
        expect_val("single_hit_inv", inv, 1);
        expect_val("single_hit_pulses", pulses_seen - p0, 1);

        // Overlaps every invincible frame: lives hold, exit on 4th tick
        for (int f = 0; f < INV_FRAMES; f++) frame(5, 2, 1, 1, "inv_hits");
        expect_val("inv_lives", lives, 2);
        expect_val("inv_exit", inv, 0);

        // Overlap only on the tick cycle, origin held 3 cycles: 2 -> 1
        frame(5, 0, 1, 3, "tick_only");
        expect_val("tick_only_lives", lives, 1);
        for (int f = 0; f < INV_FRAMES; f++) frame(4, 0, 0, 1, "recover");

        // 50 overlapping pixels in one frame: one decrement, 1 -> 0
        p0 = pulses_seen;
        frame(55, 50, 0, 1, "fifty_hits");
        step(0, 1, 3, 3, 0, 0, "after_fifty");
        expect_val("fifty_pulses", pulses_seen - p0, 1);
        expect_val("game_over", gover, 1);
        expect_val("game_over_visible", vis, 0);
        frame(6, 3, 1, 1, "hold_over");

        // Leave and restart the game
        step(0, 0, 0, 0, 0, 0, "leave");
        step(0, 0, 20, 20, 0, 0, "leave2");
        step(0, 0, 0, 0, 1, 1, "tick_while_idle");
        step(0, 1, 7, 7, 0, 0, "restart");
        expect_val("restart_lives", lives, 3);
        expect_val("restart_over", gover, 0);

        // Reset mid-invincibility, then reset on a tick cycle
        frame(4, 1, 0, 1, "hit_again");
        frame(4, 0, 0, 1, "inv_frame");
        step(1, 1, 50, 10, 0, 0, "reset_mid_inv");
        step(0, 1, 8, 8, 0, 0, "post_reset");
        frame(4, 2, 0, 0, "pre_tick");
        step(1, 1, 0, 0, 1, 1, "reset_on_tick");

        // Randomized play
        for (int f = 0; f < 80; f++) begin
            if ($urandom_range(0, 9) == 0) begin
                for (int k = 0; k < int'($urandom_range(1, 3)); k++)
                    step(0, 0, $urandom_range(0, 1) ? 0 : 12, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand_off");
            end
            if ($urandom_range(0, 24) == 0) step(1, 1, 0, 0, 0, 0, "rand_reset");
            frame($urandom_range(3, 12),
                  ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : 0,
                  1'($urandom_range(0, 3) == 0),
                  $urandom_range(1, 3), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
